// File: rtl/rn_patch_pkg.sv
// Shared encodings and sizing helper for the rn_patch window-statistic stage.
package rn_patch_pkg;

  typedef enum logic [1:0] {
    MODE_SUM9 = 2'd0,
    MODE_SUM8 = 2'd1,
    MODE_SAD8 = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Nine DW-bit taps sum to at most 9*(2^DW-1), which always fits in DW+4 bits.
  function automatic int sum_w(input int dw);
    return dw + 4;
  endfunction

endpackage

// File: rtl/rn_patch_dp.sv
// One-channel 3x3 statistic tree: row partials then final sum, 2-cycle latency.
// No backpressure; a new window may enter every cycle.
module rn_patch_dp
  import rn_patch_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vld_i,
  input  logic [1:0]      mode_i,
  input  logic [9*DW-1:0] taps_i,
  output logic [DW+3:0]   sum_o
);

  localparam int SW = sum_w(DW);
  localparam int PW = DW + 2;

  logic [8:0][DW-1:0] tap;
  logic [8:0][DW-1:0] term;
  logic [2:0][PW-1:0] row_d, row_q;
  logic               v1_d, v1_q;
  logic [SW-1:0]      sum_d, sum_q;

  always_comb begin
    tap  = taps_i;
    term = '0;
    // The centre term is zero under SAD as well, so every mode sums all nine terms.
    for (int i = 0; i < 9; i++) begin
      case (mode_e'(mode_i))
        MODE_SUM8: term[i] = (i == 4) ? '0 : tap[i];
        MODE_SAD8: term[i] = (tap[i] >= tap[4]) ? (tap[i] - tap[4]) : (tap[4] - tap[i]);
        default:   term[i] = tap[i];
      endcase
    end

    row_d = row_q;
    if (vld_i) begin
      for (int r = 0; r < 3; r++) begin
        row_d[r] = PW'(term[3*r]) + PW'(term[3*r+1]) + PW'(term[3*r+2]);
      end
    end

    v1_d  = vld_i;
    sum_d = v1_q ? (SW'(row_q[0]) + SW'(row_q[1]) + SW'(row_q[2])) : sum_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      v1_q  <= 1'b0;
      sum_q <= '0;
    end else begin
      row_q <= row_d;
      v1_q  <= v1_d;
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/rn_patch_sum.sv
// Multi-channel 3x3 patch statistic with frame position tags; 2-cycle latency.
// No backpressure: done_o is a strobe, windows arriving while flushing are dropped and flagged.
module rn_patch_sum
  import rn_patch_pkg::*;
#(
  parameter int COLS = 7,
  parameter int ROWS = 7,
  parameter int DW   = 8,
  parameter int CH   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done_i,
  input  logic [CH*9*DW-1:0]      taps_i,
  input  logic [1:0]              mode_i,
  output logic [CH*(DW+4)-1:0]    sum_o,
  output logic [$clog2(COLS)-1:0] col_o,
  output logic [$clog2(ROWS)-1:0] row_o,
  output logic                    edge_o,
  output logic                    done_o,
  output logic                    progress_done_o,
  output logic                    err_o
);

  localparam int SW = sum_w(DW);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          fl_q, fl_d;
  logic          prog_q, prog_d;
  logic          err_q, err_d;
  logic          v1_q, v1_d, v2_q, v2_d;
  logic [CW-1:0] c1_q, c1_d, c2_q, c2_d;
  logic [RW-1:0] r1_q, r1_d, r2_q, r2_d;
  logic          e1_q, e1_d, e2_q, e2_d;

  logic          accept;
  logic          last;
  logic          at_edge;
  logic [1:0]    dp_mode;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    col_d   = col_q;
    row_d   = row_q;
    fl_d    = fl_q;
    prog_d  = 1'b0;

    accept  = done_i && (state_q == ST_IDLE || state_q == ST_RUN);
    err_d   = err_q | (done_i & ~accept);
    // The frame's first window is computed in the mode being latched alongside it.
    dp_mode = (state_q == ST_IDLE) ? mode_i : mode_q;
    last    = (col_q == COL_LAST) && (row_q == ROW_LAST);
    at_edge = (col_q == '0) || (col_q == COL_LAST) || (row_q == '0) || (row_q == ROW_LAST);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          mode_d  = mode_i;
        end
      end
      ST_FLUSH: begin
        if (fl_q) begin
          state_d = ST_DONE;
          prog_d  = 1'b1;
          fl_d    = 1'b0;
        end else begin
          fl_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase

    if (accept) begin
      if (last) begin
        state_d = ST_FLUSH;
        col_d   = '0;
        row_d   = '0;
        fl_d    = 1'b0;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    v1_d = accept;
    c1_d = accept ? col_q : c1_q;
    r1_d = accept ? row_q : r1_q;
    e1_d = accept ? at_edge : e1_q;
    v2_d = v1_q;
    c2_d = v1_q ? c1_q : c2_q;
    r2_d = v1_q ? r1_q : r2_q;
    e2_d = v1_q ? e1_q : e2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 2'd0;
      col_q   <= '0;
      row_q   <= '0;
      fl_q    <= 1'b0;
      prog_q  <= 1'b0;
      err_q   <= 1'b0;
      v1_q    <= 1'b0;
      c1_q    <= '0;
      r1_q    <= '0;
      e1_q    <= 1'b0;
      v2_q    <= 1'b0;
      c2_q    <= '0;
      r2_q    <= '0;
      e2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fl_q    <= fl_d;
      prog_q  <= prog_d;
      err_q   <= err_d;
      v1_q    <= v1_d;
      c1_q    <= c1_d;
      r1_q    <= r1_d;
      e1_q    <= e1_d;
      v2_q    <= v2_d;
      c2_q    <= c2_d;
      r2_q    <= r2_d;
      e2_q    <= e2_d;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    rn_patch_dp #(.DW(DW)) u_dp (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (accept),
      .mode_i (dp_mode),
      .taps_i (taps_i[c*9*DW +: 9*DW]),
      .sum_o  (sum_o[c*SW +: SW])
    );
  end

  assign done_o          = v2_q;
  assign col_o           = c2_q;
  assign row_o           = r2_q;
  assign edge_o          = e2_q;
  assign progress_done_o = prog_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_rn_patch_sum.sv
// Directed bench for rn_patch_sum on a 4x4 frame with two 8-bit channels.
module tb_rn_patch_sum;

  logic         clk;
  logic         rst;
  logic         done_i;
  logic [143:0] taps_i;
  logic [1:0]   mode_i;
  logic [23:0]  sum_o;
  logic [1:0]   col_o;
  logic [1:0]   row_o;
  logic         edge_o;
  logic         done_o;
  logic         progress_done_o;
  logic         err_o;

  int n_chk  = 0;
  int n_pass = 0;

  rn_patch_sum #(.COLS(4), .ROWS(4), .DW(8), .CH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .done_i          (done_i),
    .taps_i          (taps_i),
    .mode_i          (mode_i),
    .sum_o           (sum_o),
    .col_o           (col_o),
    .row_o           (row_o),
    .edge_o          (edge_o),
    .done_o          (done_o),
    .progress_done_o (progress_done_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [71:0] pat(input logic [7:0] s5, input logic [7:0] oth);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = (i == 4) ? s5 : oth;
    return r;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".sum"},  32'(sum_o), 32'd0);
    chk({tag, ".col"},  32'(col_o), 32'd0);
    chk({tag, ".row"},  32'(row_o), 32'd0);
    chk({tag, ".edge"}, 32'(edge_o), 32'd0);
    chk({tag, ".done"}, 32'(done_o), 32'd0);
    chk({tag, ".prog"}, 32'(progress_done_o), 32'd0);
    chk({tag, ".err"},  32'(err_o), 32'd0);
  endtask

  // Drives a full 16-window frame back to back and checks every cycle up to t_last+4.
  task automatic run_frame(input string tag, input logic [1:0] m0, input logic [1:0] m_late,
                           input logic [71:0] w0, input logic [11:0] w0_exp,
                           input logic [71:0] c0, input logic [11:0] c0_exp,
                           input logic [71:0] c1, input logic [11:0] c1_exp,
                           input logic pulse_flush);
    int w;
    int col;
    int row;
    for (int k = 0; k < 20; k++) begin
      done_i = (k < 16) || (pulse_flush && k == 16);
      mode_i = (k < 4) ? m0 : m_late;
      taps_i = {c1, (k == 0) ? w0 : c0};
      if (k >= 2 && k <= 17) begin
        w   = k - 2;
        col = w % 4;
        row = w / 4;
        chk({tag, ".done"}, 32'(done_o), 32'd1);
        chk({tag, ".sum0"}, 32'(sum_o[11:0]), 32'((w == 0) ? w0_exp : c0_exp));
        chk({tag, ".sum1"}, 32'(sum_o[23:12]), 32'(c1_exp));
        chk({tag, ".col"},  32'(col_o), 32'(col));
        chk({tag, ".row"},  32'(row_o), 32'(row));
        chk({tag, ".edge"}, 32'(edge_o),
            32'((col == 0 || col == 3 || row == 0 || row == 3) ? 1 : 0));
      end else begin
        chk({tag, ".idle_done"}, 32'(done_o), 32'd0);
      end
      chk({tag, ".prog"}, 32'(progress_done_o), 32'((k == 18) ? 1 : 0));
      chk({tag, ".err"},  32'(err_o), 32'((pulse_flush && k >= 17) ? 1 : 0));
      tick();
    end
    done_i = 1'b0;
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    done_i = 1'b0;
    taps_i = '0;
    mode_i = 2'd0;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // SUM9 frame; mode_i moves to SAD8 mid-frame and must be ignored.
    run_frame("sum9", 2'd0, 2'd2, pat(8'd255, 8'd255), 12'd2295,
              pat(8'd100, 8'd10), 12'd180, pat(8'd3, 8'd7), 12'd59, 1'b0);

    // SUM8 frame cut short by reset after five windows.
    for (int k = 0; k < 6; k++) begin
      done_i = (k < 5);
      mode_i = 2'd1;
      taps_i = {pat(8'd3, 8'd7), pat(8'd100, 8'd10)};
      if (k >= 2) begin
        chk("sum8.done", 32'(done_o), 32'd1);
        chk("sum8.sum0", 32'(sum_o[11:0]), 32'd80);
        chk("sum8.sum1", 32'(sum_o[23:12]), 32'd56);
        chk("sum8.col",  32'(col_o), 32'(k - 2));
      end
      if (k == 5) rst = 1'b1;
      tick();
    end
    chk_zero("midrst");
    rst = 1'b0;
    tick();
    chk("midrst.flushed", 32'(done_o), 32'd0);

    // SAD8 frame restarts from (0,0); centre above and below the neighbours.
    run_frame("sad8", 2'd2, 2'd2, pat(8'd100, 8'd10), 12'd720,
              pat(8'd100, 8'd10), 12'd720, pat(8'd3, 8'd7), 12'd32, 1'b0);

    // Reserved mode computes SUM9; a window offered during FLUSH is dropped.
    run_frame("rsvd", 2'd3, 2'd0, pat(8'd100, 8'd10), 12'd180,
              pat(8'd0, 8'd255), 12'd2040, pat(8'd3, 8'd7), 12'd59, 1'b1);

    tick();
    tick();
    chk("err.sticky", 32'(err_o), 32'd1);
    chk("err.no_extra", 32'(done_o), 32'd0);
    rst = 1'b1;
    tick();
    chk("err.cleared", 32'(err_o), 32'd0);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
